accumulator_dump: RTL and testbench
===================================

ACCUMULATOR_DUMP -- requirements
Module: accumulator_dump

Interface
REQ-001 Parameter DATA_WIDTH, default 17: width of the unsigned input sample, i.e. the sum word from the upstream two-operand adder.
REQ-002 Parameter ACC_LEN, default 8: number of input samples summed per dump; legal range 2..256.
REQ-003 Parameter ACC_WIDTH, default 20: width of the accumulator and the dump output; must be >= DATA_WIDTH + ceil(log2(ACC_LEN)).
REQ-004 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-005 rst_n_i  input  1  reset; asynchronous assert, active-low.
REQ-006 data_i  input  DATA_WIDTH  unsigned sample.
REQ-007 data_valid_i  input  1  data_i is valid this cycle.
REQ-008 data_ready_o  output  1  block accepts data_i this cycle.
REQ-009 clr_i  input  1  synchronous clear of the partial accumulation.
REQ-010 sum_o  output  ACC_WIDTH  completed dump value.
REQ-011 sum_valid_o  output  1  sum_o holds an unconsumed dump.
REQ-012 sum_ready_i  input  1  downstream consumes sum_o this cycle.
REQ-013 cnt_o  output  ceil(log2(ACC_LEN))  number of samples in the current partial accumulation.

Function
REQ-014 A sample is accepted when data_valid_i = 1 and data_ready_o = 1 on the same rising edge.
REQ-015 data_ready_o is 0 exactly when cnt_o = ACC_LEN-1 and sum_valid_o = 1; otherwise it is 1. It has no combinational path from any input.
REQ-016 Accept with cnt_o < ACC_LEN-1: accumulator <= accumulator + data_i (zero-extended); cnt_o increments by 1.
REQ-017 Accept with cnt_o = ACC_LEN-1: sum_o <= accumulator + data_i; sum_valid_o <= 1; accumulator <= 0; cnt_o <= 0.
REQ-018 Latency: the dump is visible on sum_o and sum_valid_o one cycle after the ACC_LEN-th sample is accepted.
REQ-019 Addition is modulo 2^ACC_WIDTH, with no saturation. With a legal ACC_WIDTH no wrap can occur.
REQ-020 sum_valid_o clears on a rising edge where sum_valid_o = 1 and sum_ready_i = 1, unless REQ-017 loads a new dump on the same edge.
REQ-021 While sum_valid_o = 1 and sum_ready_i = 0, sum_o and sum_valid_o hold stable.
REQ-022 With clr_i = 1, accumulator <= 0 and cnt_o <= 0, and any sample offered that cycle is discarded (clr_i wins over acceptance).
REQ-023 clr_i does not affect sum_o or sum_valid_o.
REQ-024 State machine:
- ACC: cnt_o < ACC_LEN-1, or sum_valid_o = 0.
- STALL: cnt_o = ACC_LEN-1 and sum_valid_o = 1, so data_ready_o = 0.
- STALL -> ACC when sum_ready_i = 1 or clr_i = 1.
- ACC -> STALL when cnt_o reaches ACC_LEN-1 while a dump is still pending.
REQ-025 Samples with data_valid_i = 0 leave the accumulator and cnt_o unchanged.

Reset
REQ-026 While rst_n_i = 0, independent of clk_i:
- accumulator = 0, cnt_o = 0
- sum_o = 0, sum_valid_o = 0
- data_ready_o = 1
REQ-027 Reset asserted mid-accumulation discards the partial sum. After release, the next dump contains only samples accepted after release.
REQ-028 The first sample can be accepted on the first rising edge after rst_n_i deasserts.

Verification (ACC_LEN=4, DATA_WIDTH=17, ACC_WIDTH=19)
REQ-029 Four back-to-back samples 0x7526, sum_ready_i = 1 -> sum_o = 0x1D498 with sum_valid_o high for one cycle, one cycle after the 4th accept; cnt_o returns to 0.
REQ-030 Four samples 0x1FFFF -> sum_o = 0x7FFFC, no wrap.
REQ-031 Backpressure: sum_ready_i = 0, eight samples 0x0001 offered continuously:
- first dump = 0x4, held stable
- three further samples are accepted, then data_ready_o = 0
- after sum_ready_i = 1 for one cycle, the 8th sample is accepted and the second dump = 0x4
REQ-032 Clear: two samples 0x0100, then clr_i = 1 together with a valid sample 0x0100, then four samples 0x0010 -> sum_o = 0x40.
REQ-033 Reset mid-operation:
- accept 3 samples 0x0005, then pulse rst_n_i low between edges
- outputs go to zero asynchronously
- then accept 4 samples 0x0002 -> sum_o = 0x8
REQ-034 Gaps: samples 0x0003 with data_valid_i toggling every other cycle -> sum_o = 0xC after the 4th accept; cnt_o is unchanged on idle cycles.

Source files
------------

// File: rtl/accumulator_dump.sv
// Sums ACC_LEN unsigned samples per dump and holds each dump on a valid/ready
// output; the input stalls only when a new dump would overwrite an unconsumed one.
module accumulator_dump #(
  parameter  int unsigned DATA_WIDTH = 17,
  parameter  int unsigned ACC_LEN    = 8,
  parameter  int unsigned ACC_WIDTH  = 20,
  localparam int unsigned CNT_W      = $clog2(ACC_LEN)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  data_valid_i,
  output logic                  data_ready_o,
  input  logic                  clr_i,
  output logic [ACC_WIDTH-1:0]  sum_o,
  output logic                  sum_valid_o,
  input  logic                  sum_ready_i,
  output logic [CNT_W-1:0]      cnt_o
);

  typedef enum logic {
    ST_ACC   = 1'b0,
    ST_STALL = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

  state_e                 state_q, state_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [ACC_WIDTH-1:0]   sum_q, sum_d;
  logic                   sum_valid_q, sum_valid_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic [ACC_WIDTH-1:0]   data_ext;
  logic                   accept;
  logic                   dump;

  assign data_ext = ACC_WIDTH'(data_i);
  // clr_i discards any sample offered in the same cycle.
  assign accept   = data_valid_i && data_ready_o && !clr_i;
  assign dump     = accept && (cnt_q == LAST_CNT);

  // State and datapath registers.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= ST_ACC;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;

    if (clr_i) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (dump) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (accept) begin
      acc_d = acc_q + data_ext;
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A fresh dump takes priority over consumption of the previous one.
    if (dump) begin
      sum_d       = acc_q + data_ext;
      sum_valid_d = 1'b1;
    end else if (sum_valid_q && sum_ready_i) begin
      sum_valid_d = 1'b0;
    end

    // STALL is exactly "last slot reached while a dump is still pending".
    state_d = ((cnt_d == LAST_CNT) && sum_valid_d) ? ST_STALL : ST_ACC;
  end

  // Outputs come straight from registers; data_ready_o has no input path.
  always_comb begin
    data_ready_o = (state_q == ST_ACC);
    sum_o        = sum_q;
    sum_valid_o  = sum_valid_q;
    cnt_o        = cnt_q;
  end

endmodule

// File: tb/tb_accumulator_dump.sv
// Directed bench for accumulator_dump with ACC_LEN=4, DATA_WIDTH=17, ACC_WIDTH=19.
module tb_accumulator_dump;

  localparam int unsigned DW = 17;
  localparam int unsigned AL = 4;
  localparam int unsigned AW = 19;
  localparam int unsigned CW = 2;

  logic          clk_i;
  logic          rst_n_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic          clr_i;
  logic [AW-1:0] sum_o;
  logic          sum_valid_o;
  logic          sum_ready_i;
  logic [CW-1:0] cnt_o;

  int checks = 0;
  int errors = 0;

  accumulator_dump #(
    .DATA_WIDTH(DW),
    .ACC_LEN   (AL),
    .ACC_WIDTH (AW)
  ) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .data_i      (data_i),
    .data_valid_i(data_valid_i),
    .data_ready_o(data_ready_o),
    .clr_i       (clr_i),
    .sum_o       (sum_o),
    .sum_valid_o (sum_valid_o),
    .sum_ready_i (sum_ready_i),
    .cnt_o       (cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Checks all four outputs at once.
  task automatic check_out(input string tag, input logic rdy, input logic [AW-1:0] sum,
                           input logic vld, input logic [CW-1:0] cnt);
    check({tag, ".ready"}, 32'(data_ready_o), 32'(rdy));
    check({tag, ".sum"},   32'(sum_o),        32'(sum));
    check({tag, ".valid"}, 32'(sum_valid_o),  32'(vld));
    check({tag, ".cnt"},   32'(cnt_o),        32'(cnt));
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_n_i      = 1'b0;
    data_i       = '0;
    data_valid_i = 1'b0;
    clr_i        = 1'b0;
    sum_ready_i  = 1'b0;

    // Reset values, checked before any clock edge and again after edges in reset.
    #3;
    check_out("reset_async", 1'b1, '0, 1'b0, 2'd0);
    data_valid_i = 1'b1;
    data_i       = 17'h1FFFF;
    repeat (2) tick();
    check_out("reset_held", 1'b1, '0, 1'b0, 2'd0);
    #2;
    rst_n_i = 1'b1;

    // Back-to-back 0x7526, first accept on the first edge after release.
    data_i      = 17'h7526;
    sum_ready_i = 1'b1;
    tick();
    check("b2b.cnt1", 32'(cnt_o), 32'd1);
    tick();
    tick();
    check_out("b2b.pre", 1'b1, '0, 1'b0, 2'd3);
    tick();
    data_valid_i = 1'b0;
    check_out("b2b.dump", 1'b1, 19'h1D498, 1'b1, 2'd0);
    tick();
    check_out("b2b.consumed", 1'b1, 19'h1D498, 1'b0, 2'd0);

    // Maximum samples: no wrap.
    data_valid_i = 1'b1;
    data_i       = 17'h1FFFF;
    repeat (4) tick();
    data_valid_i = 1'b0;
    check_out("max.dump", 1'b1, 19'h7FFFC, 1'b1, 2'd0);
    tick();
    check("max.consumed", 32'(sum_valid_o), 32'd0);

    // Backpressure with eight samples 0x0001 offered continuously.
    sum_ready_i  = 1'b0;
    data_valid_i = 1'b1;
    data_i       = 17'h00001;
    repeat (4) tick();
    check_out("bp.dump1", 1'b1, 19'h4, 1'b1, 2'd0);
    tick();
    check_out("bp.s5", 1'b1, 19'h4, 1'b1, 2'd1);
    tick();
    tick();
    check_out("bp.stall", 1'b0, 19'h4, 1'b1, 2'd3);
    tick();
    check_out("bp.stall_hold", 1'b0, 19'h4, 1'b1, 2'd3);
    sum_ready_i = 1'b1;
    tick();
    sum_ready_i = 1'b0;
    check_out("bp.released", 1'b1, 19'h4, 1'b0, 2'd3);
    tick();
    data_valid_i = 1'b0;
    sum_ready_i  = 1'b1;
    check_out("bp.dump2", 1'b1, 19'h4, 1'b1, 2'd0);
    tick();
    check("bp.consumed", 32'(sum_valid_o), 32'd0);

    // Clear discards the partial sum and the sample offered alongside it.
    data_valid_i = 1'b1;
    data_i       = 17'h00100;
    tick();
    tick();
    check("clr.pre_cnt", 32'(cnt_o), 32'd2);
    clr_i = 1'b1;
    tick();
    clr_i = 1'b0;
    check_out("clr.after", 1'b1, 19'h4, 1'b0, 2'd0);
    data_i      = 17'h00010;
    sum_ready_i = 1'b0;
    repeat (4) tick();
    check_out("clr.dump", 1'b1, 19'h40, 1'b1, 2'd0);

    // Reset mid-operation with a pending dump and a full partial sum.
    data_i = 17'h00005;
    repeat (3) tick();
    check_out("rst.pre", 1'b0, 19'h40, 1'b1, 2'd3);
    rst_n_i = 1'b0;
    #1;
    check_out("rst.async", 1'b1, '0, 1'b0, 2'd0);
    data_i      = 17'h00002;
    sum_ready_i = 1'b1;
    #2;
    rst_n_i = 1'b1;
    tick();
    check("rst.first_accept", 32'(cnt_o), 32'd1);
    repeat (3) tick();
    data_valid_i = 1'b0;
    check_out("rst.dump", 1'b1, 19'h8, 1'b1, 2'd0);
    tick();
    check("rst.consumed", 32'(sum_valid_o), 32'd0);

    // Gaps: valid on every other cycle.
    data_i = 17'h00003;
    for (int i = 0; i < 7; i++) begin
      data_valid_i = (i % 2 == 0);
      tick();
      check($sformatf("gap.cnt%0d", i), 32'(cnt_o), 32'(((i / 2) + 1) % AL));
    end
    data_valid_i = 1'b0;
    check_out("gap.dump", 1'b1, 19'hC, 1'b1, 2'd0);
    tick();
    check("gap.consumed", 32'(sum_valid_o), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
